alu_seq: RTL
============

# alu_seq

Sequential, parametrised successor of the gate-level 4-bit ALU. Accepts one operation at a time through a valid/ready input handshake and executes ADD, SUB, NAND and NOR in one cycle. MUL runs as a WIDTH-cycle shift-add. The result is held in an output register with a valid/ready output handshake, so the block can sit between pipelined producers and consumers in the datapath.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operation request.
- o_ready  output  1  block can accept a request.
- i_op1  input  WIDTH  operand 1, unsigned.
- i_op2  input  WIDTH  operand 2, unsigned.
- i_ctrl  input  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 NAND, 4 NOR, 5..7 illegal.
- o_valid  output  1  result available.
- i_ready  input  1  consumer takes the result.
- o_dat  output  2*WIDTH  result.
- o_carry  output  1  ADD carry-out or SUB borrow-out; 0 for all other opcodes.
- o_err  output  1  the held result came from an illegal opcode.

## Operation
- States:
  - IDLE: o_ready=1, o_valid=0.
  - MUL: o_ready=0, o_valid=0.
  - DONE: o_ready=0, o_valid=1.
- Accept: i_valid && o_ready in IDLE. i_op1, i_op2 and i_ctrl are captured on that edge. Later changes to these inputs are ignored until the next accept.
- ADD, SUB, NAND, NOR and illegal opcodes: the result is registered on the accept edge. State goes to DONE.
- Result widths:
  - ADD: o_dat[WIDTH-1:0] = (op1+op2) mod 2^WIDTH; o_carry = bit WIDTH of the sum.
  - SUB: o_dat[WIDTH-1:0] = (op1-op2) mod 2^WIDTH; o_carry = (op1 < op2).
  - NAND and NOR: bitwise over WIDTH bits.
  - For all four, o_dat[2*WIDTH-1:WIDTH] = 0.
  - Illegal opcode: o_dat = 0, o_carry = 0, o_err = 1. For every legal opcode, o_err = 0.
- MUL:
  - On accept, load the registers and enter MUL:
    - acc = 0 (2*WIDTH bits);
    - mcand = zero-extended op1 (2*WIDTH bits);
    - mplier = op2 (WIDTH bits);
    - cnt = 0.
  - Each MUL cycle:
    - if mplier[0], acc += mcand;
    - mcand <<= 1; mplier >>= 1; cnt++.
  - After the cycle with cnt == WIDTH-1, load o_dat = final acc and set o_carry = 0. Go to DONE.
  - Result is the full unsigned 2*WIDTH product; no overflow is possible.
- DONE:
  - o_dat, o_carry and o_err are held stable while i_ready = 0.
  - On i_ready = 1, go to IDLE. o_valid drops on the next edge.
  - No new accept happens in the handshake cycle.
- Reset values:
  - state IDLE; o_valid 0; o_ready 1; o_dat 0; o_carry 0; o_err 0;
  - acc, mcand, mplier and cnt all 0.

## Timing
- Latency from accept edge to o_valid high:
  - 1 cycle for ADD, SUB, NAND, NOR and illegal opcodes;
  - WIDTH+1 cycles for MUL.
- Minimum initiation interval is latency + 1 cycle: the DONE handshake cycle, then the IDLE accept.
- o_ready and o_valid are functions of state only. They have no combinational path from i_valid or i_ready.
- i_rst_n assertion clears all state immediately, including in the middle of a MUL. The partial product is discarded and no o_valid is produced for the aborted operation.
- Reset deassertion is synchronised to i_clk outside this block.
- i_valid high outside IDLE is ignored. The request is not latched and is not lost silently: the producer must hold it until o_ready is 1.

## Structure
- Package alu_seq_pkg holds:
  - the opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_NAND, OP_NOR);
  - the state enum (ST_IDLE, ST_MUL, ST_DONE).
- One sub-module, alu_seq_mul, holds the shift-add datapath: acc, mcand, mplier, cnt and a done pulse. It is started by a load strobe from the top-level FSM. The top level holds the FSM, the single-cycle ops and the output register.

## Test plan
All scenarios use WIDTH=8.
- ADD 200+100, i_ready=1 → one cycle after accept: o_valid=1, o_dat=0x002C, o_carry=1, o_err=0.
- SUB 5-9 → o_dat=0x00FC, o_carry=1. SUB 9-5 → o_dat=0x0004, o_carry=0.
- MUL 255×255 → o_ready=0 for 8 cycles; o_valid rises 9 cycles after accept with o_dat=0xFE01. MUL 0×37 → o_dat=0x0000 at the same latency.
- NAND 0xF0,0xCC → o_dat=0x003F. NOR 0xF0,0xCC → o_dat=0x0003. Illegal opcode 6 → o_dat=0, o_err=1, o_carry=0.
- Backpressure: ADD result held with i_ready=0 for 5 cycles → o_dat, o_carry and o_valid stable, and a concurrent i_valid is not accepted. i_ready=1 → o_valid=0 and o_ready=1 on the next edge.
- Reset after 4 MUL cycles → all outputs at reset values immediately. After release, a new ADD 1+1 returns o_dat=0x0002 with no stale MUL result.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encoding and controller states.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between a producer/consumer and alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 8
);

  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_op1;
  logic [WIDTH-1:0]   i_op2;
  logic [2:0]         i_ctrl;
  logic               o_valid;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_dat;
  logic               o_carry;
  logic               o_err;

  modport master (
    output i_valid, i_op1, i_op2, i_ctrl, i_ready,
    input  o_ready, o_valid, o_dat, o_carry, o_err
  );

  modport slave (
    input  i_valid, i_op1, i_op2, i_ctrl, i_ready,
    output o_ready, o_valid, o_dat, o_carry, o_err
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles per load.
// prod/done are combinational so the caller can register the final sum on the last cycle.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  output logic [2*WIDTH-1:0] prod,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic [2*WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign prod     = acc_next;
  assign done     = busy && (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, op1};
      mplier <= op2;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/NAND/NOR, WIDTH-cycle MUL, registered result handshake.
//   state   | meaning
//   ST_IDLE | ready for a request, no result held
//   ST_MUL  | shift-add multiply in progress
//   ST_DONE | result held until the consumer takes it
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic     i_clk,
  input logic     i_rst_n,
  alu_seq_if.slave bus
);

  state_e             state;
  logic               ready_q;
  logic               valid_q;
  logic [2*WIDTH-1:0] dat_q;
  logic               carry_q;
  logic               err_q;

  logic               mul_load;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_done;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   res_lo;
  logic               res_carry;
  logic               res_err;

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_dat   = dat_q;
  assign bus.o_carry = carry_q;
  assign bus.o_err   = err_q;

  assign mul_load = (state == ST_IDLE) && bus.i_valid && (bus.i_ctrl == OP_MUL);

  // The extra top bit of the difference is the borrow, i.e. op1 < op2.
  assign sum  = {1'b0, bus.i_op1} + {1'b0, bus.i_op2};
  assign diff = {1'b0, bus.i_op1} - {1'b0, bus.i_op2};

  always_comb begin
    res_lo    = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    case (bus.i_ctrl)
      OP_ADD:  begin res_lo = sum[WIDTH-1:0];  res_carry = sum[WIDTH];  end
      OP_SUB:  begin res_lo = diff[WIDTH-1:0]; res_carry = diff[WIDTH]; end
      OP_NAND: res_lo = ~(bus.i_op1 & bus.i_op2);
      OP_NOR:  res_lo = ~(bus.i_op1 | bus.i_op2);
      OP_MUL:  ;
      default: res_err = 1'b1;
    endcase
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .load    (mul_load),
    .op1     (bus.i_op1),
    .op2     (bus.i_op2),
    .prod    (mul_prod),
    .done    (mul_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      dat_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_valid) begin
            ready_q <= 1'b0;
            if (bus.i_ctrl == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              state   <= ST_DONE;
              valid_q <= 1'b1;
              dat_q   <= {{WIDTH{1'b0}}, res_lo};
              carry_q <= res_carry;
              err_q   <= res_err;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state   <= ST_DONE;
            valid_q <= 1'b1;
            dat_q   <= mul_prod;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
